// File: rtl/full_adder_pkg.sv
// Shared constants, the per-bit {cout,sum} result type and the bit-level
// full-adder equations used by full_adder_cell.
package full_adder_pkg;

    localparam int FA_WIDTH_DEF = 1;
    localparam int FA_CNT_W_DEF = 16;
    localparam int FA_WIDTH_MAX = 64;

    typedef struct packed {
        logic cout;
        logic sum;
    } fa_bit_res_t;

    function automatic fa_bit_res_t fa_bit_add(input logic a, input logic b, input logic cin);
        fa_bit_res_t r;
        r.sum  = a ^ b ^ cin;
        r.cout = (a & b) | (a & cin) | (b & cin);
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; WIDTH copies are chained by full_adder to form the
// ripple-carry adder.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    fa_bit_res_t res;

    assign res  = fa_bit_add(a, b, cin);
    assign sum  = res.sum;
    assign cout = res.cout;

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with a combinational result, a one-cycle registered copy
// and, when FULL_ADDER_STATS_EN is defined, a saturating carry-out event counter.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH_DEF,
    parameter int CNT_W = FA_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid
`ifdef FULL_ADDER_STATS_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

    // in_valid qualifies a/b/cin at each rising edge. There is no ready: every
    // valid beat is accepted and shows up on sum_q/cout_q with out_valid one
    // cycle later; an idle edge drops out_valid but keeps the last result.
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             vld_q, vld_d;

    always_comb begin
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        vld_d      = in_valid;
        if (in_valid) begin
            res_sum_d  = sum;
            res_cout_d = cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            vld_q      <= vld_d;
        end
    end

    assign sum_q     = res_sum_q;
    assign cout_q    = res_cout_q;
    assign out_valid = vld_q;

`ifdef FULL_ADDER_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Sticks at all-ones so a long run of carries never reads as a small count.
    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && cout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: exhaustive 1-bit combinational table plus an 8-bit
// registered path checked through an expected-result queue.
module tb_full_adder;

    logic clk;
    logic rst_n;

    logic       a1, b1, cin1;
    logic       sum1, cout1, sum_q1, cout_q1, out_valid1;

    logic [7:0] a8, b8;
    logic       cin8, v8;
    logic [7:0] sum8, sum_q8;
    logic       cout8, cout_q8, out_valid8;
`ifdef FULL_ADDER_STATS_EN
    logic [1:0] carry_cnt8;
    logic [3:0] carry_cnt1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];
    logic       vld_q[$];
    logic [8:0] mon_exp;
    logic       mon_v;

    full_adder #(.WIDTH(1), .CNT_W(4)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .in_valid  (1'b0),
        .sum       (sum1),
        .cout      (cout1),
        .sum_q     (sum_q1),
        .cout_q    (cout_q1),
        .out_valid (out_valid1)
`ifdef FULL_ADDER_STATS_EN
        ,
        .carry_cnt (carry_cnt1)
`endif
    );

    full_adder #(.WIDTH(8), .CNT_W(2)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .in_valid  (v8),
        .sum       (sum8),
        .cout      (cout8),
        .sum_q     (sum_q8),
        .cout_q    (cout_q8),
        .out_valid (out_valid8)
`ifdef FULL_ADDER_STATS_EN
        ,
        .carry_cnt (carry_cnt8)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: one beat on the 8-bit instance, applied at the falling edge
    task automatic step8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input logic tv);
        logic [8:0] m;
        @(negedge clk);
        a8   = ta;
        b8   = tb_v;
        cin8 = tc;
        v8   = tv;
        m    = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tc};
        #1;
        check("sum8_comb", sum8, m[7:0]);
        check("cout8_comb", cout8, m[8]);
        vld_q.push_back(tv);
        if (tv) exp_q.push_back(m);
    endtask

    // scoreboard: every driven beat expects out_valid exactly one edge later
    always @(negedge clk) begin
        if (vld_q.size() > 0) begin
            mon_v = vld_q.pop_front();
            check("out_valid", out_valid8, mon_v);
            if (mon_v) begin
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check("sum_q", sum_q8, mon_exp[7:0]);
                    check("cout_q", cout_q8, mon_exp[8]);
                end else begin
                    check("exp_q_underflow", 1, 0);
                end
            end
        end
    end

    logic [1:0] tbl1 [8];
    int exp_cnt;

    initial begin
        tbl1 = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0; v8 = 1'b0;
        exp_cnt = 0;
        #1;
        check("rst_sum_q", sum_q8, 8'h00);
        check("rst_cout_q", cout_q8, 1'b0);
        check("rst_out_valid", out_valid8, 1'b0);
`ifdef FULL_ADDER_STATS_EN
        check("rst_carry_cnt", carry_cnt8, 2'd0);
`endif

        // 1-bit truth table, one combination every 10 time units
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            #1;
            check("sum1", sum1, tbl1[i][1]);
            check("cout1", cout1, tbl1[i][0]);
            #9;
        end

        @(negedge clk);
        rst_n = 1'b1;

        // overflow wrap and single-beat latency, then an idle edge
        step8(8'hFF, 8'h01, 1'b0, 1'b1);
        step8(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("hold_sum_q", sum_q8, 8'h00);
        check("hold_cout_q", cout_q8, 1'b1);

        // back-to-back stream
        step8(8'h10, 8'h20, 1'b1, 1'b1);
        step8(8'h80, 8'h80, 1'b0, 1'b1);
        step8(8'h7F, 8'h00, 1'b1, 1'b1);
        step8(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("hold2_sum_q", sum_q8, 8'h80);
        check("hold2_cout_q", cout_q8, 1'b0);

        // a few random beats with random idles
        for (int i = 0; i < 20; i++) begin
            step8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        step8(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        // reset between edges while a result is in flight
        step8(8'h12, 8'h34, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        vld_q.delete();
        #1;
        check("midrst_sum_q", sum_q8, 8'h00);
        check("midrst_cout_q", cout_q8, 1'b0);
        check("midrst_out_valid", out_valid8, 1'b0);
`ifdef FULL_ADDER_STATS_EN
        check("midrst_carry_cnt", carry_cnt8, 2'd0);
`endif
        a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1; v8 = 1'b0;
        #1;
        check("midrst_sum_comb", sum8, 8'h11);
        check("midrst_cout_comb", cout8, 1'b1);
        @(negedge clk);
        #1;
        check("inrst_out_valid", out_valid8, 1'b0);
        rst_n = 1'b1;

        step8(8'hAA, 8'h55, 1'b1, 1'b0);
        step8(8'h01, 8'h02, 1'b0, 1'b1);
        step8(8'h00, 8'h00, 1'b0, 1'b0);

`ifdef FULL_ADDER_STATS_EN
        // carry events saturating at 3; an idle edge with cout=1 must not count
        @(negedge clk);
        check("cnt_start", carry_cnt8, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step8(8'hFF, 8'h01, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            if (exp_cnt < 3) exp_cnt++;
            check("carry_cnt", carry_cnt8, 2'(exp_cnt));
            if (i == 0) begin
                step8(8'hFF, 8'h01, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                check("carry_cnt_idle", carry_cnt8, 2'(exp_cnt));
            end
        end
        step8(8'h00, 8'h00, 1'b0, 1'b0);
`endif

        @(negedge clk);
        @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 0);
        check("vld_q_drained", 64'(vld_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
